// File: rtl/fpu_pkg.sv
// Shared constants, state encoding and NaN helper for the min/max reduction engine.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [FP_W-1:0] CANON_NAN = 32'hFFC00000;
  localparam logic            FMAX      = 1'b1;
  localparam logic            FMIN      = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  // Exponent all ones with a nonzero fraction; infinities are not NaN.
  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[FRAC_W +: EXP_W] == {EXP_W{1'b1}}) && (x[FRAC_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_minmax_cmp.sv
// Combinational IEEE-754 single-precision max/min of two operands; ties return a.
module fp_minmax_cmp
  import fpu_pkg::*;
#(
  parameter logic [31:0] NanVal = 32'hFFC00000
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mode,
  output logic [31:0] y
);

  logic        sign_a;
  logic        sign_b;
  logic [30:0] mag_a;
  logic [30:0] mag_b;
  logic        a_nan;
  logic        b_nan;
  logic        a_gt;
  logic        b_gt;

  assign sign_a = a[FP_W-1];
  assign sign_b = b[FP_W-1];
  // Exponent sits above fraction, so an unsigned compare orders magnitudes.
  assign mag_a  = a[FP_W-2:0];
  assign mag_b  = b[FP_W-2:0];
  assign a_nan  = is_nan(a);
  assign b_nan  = is_nan(b);

  // Decide which operand is numerically larger, then select per mode.
  always_comb begin
    a_gt = 1'b0;
    b_gt = 1'b0;
    if (sign_a != sign_b) begin
      a_gt = ~sign_a;
      b_gt = sign_a;
    end else if (!sign_a) begin
      a_gt = mag_a > mag_b;
      b_gt = mag_b > mag_a;
    end else begin
      a_gt = mag_a < mag_b;
      b_gt = mag_b < mag_a;
    end

    if (a_nan || b_nan) begin
      y = NanVal;
    end else if (mode == FMAX) begin
      y = b_gt ? b : a;
    end else begin
      y = a_gt ? b : a;
    end
  end

endmodule

// File: rtl/fpu_minmax_reduce.sv
// Streaming max/min reduction over a packet of single-precision values, one result per packet.
module fpu_minmax_reduce #(
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] CANON_NAN = fpu_pkg::CANON_NAN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_nan,
  output logic [CNT_W-1:0] out_count
);

  import fpu_pkg::state_e;
  import fpu_pkg::IDLE;
  import fpu_pkg::ACCUM;
  import fpu_pkg::DONE;
  import fpu_pkg::is_nan;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic             nan_q, nan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic        in_fire;
  logic        out_fire;
  logic [31:0] cmp_y;

  fp_minmax_cmp #(
    .NanVal(CANON_NAN)
  ) u_cmp (
    .a   (acc_q),
    .b   (in_data),
    .mode(mode_q),
    .y   (cmp_y)
  );

  // Handshake and result outputs; reset masks them so a pending result is never seen.
  always_comb begin
    in_ready  = !rst && (state_q != DONE);
    out_valid = !rst && (state_q == DONE);
    out_data  = '0;
    out_nan   = 1'b0;
    out_count = '0;
    if (out_valid) begin
      out_data  = nan_q ? CANON_NAN : acc_q;
      out_nan   = nan_q;
      out_count = cnt_q;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state: first element seeds the accumulator, later ones fold through the comparator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    nan_d   = nan_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          mode_d  = mode;
          acc_d   = in_data;
          nan_d   = is_nan(in_data);
          cnt_d   = CNT_W'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d   = cmp_y;
          nan_d   = nan_q | is_nan(in_data);
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      nan_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nan_q   <= nan_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // An element must never be taken while a result is waiting.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(in_fire && state_q == DONE));
    end
  end

endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// Directed, table-driven bench for the min/max reduction engine.
module tb_fpu_minmax_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_nan;
  logic [31:0] out_data;
  logic [15:0] out_count;

  logic        in_ready2, out_valid2, out_nan2;
  logic [31:0] out_data2;
  logic [1:0]  out_count2;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_minmax_reduce #(.CNT_W(16), .CANON_NAN(32'hFFC00000)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nan(out_nan), .out_count(out_count)
  );

  fpu_minmax_reduce #(.CNT_W(2), .CANON_NAN(32'hFFC00000)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_nan(out_nan2), .out_count(out_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one element and hold it until it is taken at a rising edge.
  task automatic send_elem(input logic [31:0] d, input logic last, input logic m);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Result must be valid in the cycle after the last transfer; consumed if out_ready=1.
  task automatic check_result(input string name, input logic [31:0] exp_d, input logic exp_n,
                              input int exp_c);
    int guard;
    int sat_c;
    sat_c = (exp_c > 3) ? 3 : exp_c;
    @(negedge clk);
    chk({name, " out_valid"}, {31'b0, out_valid}, 32'd1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({name, " out_data"}, out_data, exp_d);
    chk({name, " out_nan"}, {31'b0, out_nan}, {31'b0, exp_n});
    chk({name, " out_count"}, {16'b0, out_count}, 32'(exp_c));
    chk({name, " out_data_w2"}, out_data2, exp_d);
    chk({name, " out_count_w2"}, {30'b0, out_count2}, 32'(sat_c));
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic        m;
    int          n;
    logic [31:0] d[5];
    logic [31:0] exp_d;
    logic        exp_n;
    int          exp_c;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{1'b1, 3, '{32'h3F800000, 32'hC0000000, 32'h40400000, 0, 0}, 32'h40400000, 1'b0, 3};
    vecs[1]  = '{1'b0, 2, '{32'h00000000, 32'h80000000, 0, 0, 0}, 32'h80000000, 1'b0, 2};
    vecs[2]  = '{1'b1, 2, '{32'h00000000, 32'h80000000, 0, 0, 0}, 32'h00000000, 1'b0, 2};
    vecs[3]  = '{1'b0, 2, '{32'hC0400000, 32'hC0000000, 0, 0, 0}, 32'hC0400000, 1'b0, 2};
    vecs[4]  = '{1'b1, 3, '{32'h3F800000, 32'h7FC00001, 32'h7F800000, 0, 0}, 32'hFFC00000, 1'b1, 3};
    vecs[5]  = '{1'b0, 1, '{32'h42280000, 0, 0, 0, 0}, 32'h42280000, 1'b0, 1};
    vecs[6]  = '{1'b1, 1, '{32'h7F800001, 0, 0, 0, 0}, 32'hFFC00000, 1'b1, 1};
    vecs[7]  = '{1'b1, 2, '{32'hFF800000, 32'hC1200000, 0, 0, 0}, 32'hC1200000, 1'b0, 2};
    vecs[8]  = '{1'b0, 3, '{32'h7F800000, 32'h3F800000, 32'h00800000, 0, 0}, 32'h00800000, 1'b0, 3};
    vecs[9]  = '{1'b0, 3, '{32'h3F000000, 32'hBF000000, 32'h3F800000, 0, 0}, 32'hBF000000, 1'b0, 3};
    vecs[10] = '{1'b1, 4, '{32'h7FC00000, 32'h3F800000, 32'h40000000, 32'hFF800000, 0},
                 32'hFFC00000, 1'b1, 4};

    rst       = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_nan", {31'b0, out_nan}, 32'd0);
    chk("rst out_count", {16'b0, out_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle in_ready", {31'b0, in_ready}, 32'd1);

    // Table-driven packets
    for (int i = 0; i < NV; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send_elem(vecs[i].d[j], (j == vecs[i].n - 1), vecs[i].m);
      end
      check_result($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_n, vecs[i].exp_c);
    end

    // Backpressure: result held stable, no elements taken
    out_ready = 1'b0;
    send_elem(32'h3F800000, 1'b0, 1'b1);
    send_elem(32'h40000000, 1'b1, 1'b1);
    check_result("bp", 32'h40000000, 1'b0, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h7FC00000;
      in_last  = 1'b1;
      #1;
      chk($sformatf("bp%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp%0d out_data", k), out_data, 32'h40000000);
      chk($sformatf("bp%0d out_nan", k), {31'b0, out_nan}, 32'd0);
      chk($sformatf("bp%0d out_count", k), {16'b0, out_count}, 32'd2);
      chk($sformatf("bp%0d in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_elem(32'hBF800000, 1'b1, 1'b1);
    check_result("after_bp", 32'hBF800000, 1'b0, 1);

    // Mid-packet reset discards the partial packet
    send_elem(32'h3F800000, 1'b0, 1'b1);
    send_elem(32'h40000000, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("postrst%0d out_valid", k), {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    send_elem(32'h42280000, 1'b1, 1'b0);
    check_result("postrst_pkt", 32'h42280000, 1'b0, 1);

    // Mode latched on the first element only
    send_elem(32'h40000000, 1'b0, 1'b0);
    send_elem(32'h40000000, 1'b1, 1'b1);
    check_result("tie_fmin", 32'h40000000, 1'b0, 2);
    send_elem(32'h40000000, 1'b0, 1'b0);
    send_elem(32'h40400000, 1'b1, 1'b1);
    check_result("mode_latch", 32'h40000000, 1'b0, 2);

    // Count saturation on the narrow-counter instance
    send_elem(32'h3F800000, 1'b0, 1'b1);
    send_elem(32'h40000000, 1'b0, 1'b1);
    send_elem(32'h40400000, 1'b0, 1'b1);
    send_elem(32'h40800000, 1'b0, 1'b1);
    send_elem(32'h40A00000, 1'b1, 1'b1);
    check_result("sat5", 32'h40A00000, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_minmax_reduce.md
Name: fpu_minmax_reduce

Overview:
- Streaming reduction engine that drives the FPU max/min compare function over a packet of IEEE-754 single-precision values.
- Returns one max or min result per packet.
- Sits between an operand source with a valid/ready stream and a result consumer. It issues each accepted element plus the running accumulator into a compare stage and collects the winner.
- Turns the single-shot two-operand compare into a sequenced, handshaked vector operation.

Parameters:
- CNT_W, 16, width of the element counter reported with each result; the counter saturates at 2^CNT_W-1.
- CANON_NAN, 32'hFFC00000, value returned when any element of the packet is NaN.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  1 = fmax, 0 = fmin. Sampled only with the first element of a packet.
- in_valid  in  1  element present.
- in_ready  out  1  engine can accept an element this cycle.
- in_data  in  32  IEEE-754 single element.
- in_last  in  1  marks the final element of the packet.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  reduced max/min, or CANON_NAN.
- out_nan  out  1  at least one element in the packet was NaN.
- out_count  out  CNT_W  number of elements accepted in the packet (saturating).

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. While rst=1 at a clock edge:
  - state=IDLE
  - in_ready=0 for the reset cycle, then 1 in IDLE
  - out_valid=0, out_data=0, out_nan=0, out_count=0
  - accumulator, nan flag and mode register cleared
- A reset asserted mid-packet or with a result pending discards all state. No result is emitted.
- Handshakes:
  - Transfer occurs when valid and ready are both 1 at a clock edge.
  - out_data, out_nan and out_count stay stable while out_valid=1 and out_ready=0.
- FSM states:
  - IDLE: in_ready=1. On an input transfer:
    - latch mode into mode_q.
    - acc <= in_data; nan_q <= isNaN(in_data); cnt <= 1.
    - If in_last=1, go to DONE; otherwise go to ACCUM.
  - ACCUM: in_ready=1. On an input transfer:
    - acc <= cmp(acc, in_data, mode_q); acc is operand A, the element is operand B.
    - nan_q |= isNaN(in_data); cnt <= sat(cnt+1).
    - If in_last=1, go to DONE.
    - No transfer means hold state.
  - DONE: in_ready=0 and out_valid=1.
    - out_data = nan_q ? CANON_NAN : acc.
    - On an output transfer, go to IDLE. Back-to-back packets therefore have a one-cycle bubble.
- Latency: out_valid rises in the cycle after the last element transfers. Accumulator update is 1 cycle per element, so throughput is 1 element/clk.
- Compare rules, identical to the FPU comparator:
  - NaN: exponent 8'hFF with nonzero fraction. Either operand NaN gives CANON_NAN.
  - Signs differ: fmax picks the positive operand, fmin the negative. So fmax(+0,-0)=+0 and fmin(+0,-0)=-0.
  - Same sign: compare the exponent first, then the fraction. Magnitude order is inverted for negative operands.
  - Exact tie: the result is A (the accumulator), so the earlier element wins.
  - Infinities compare as ordinary max-exponent values.
- NaN is sticky: once nan_q=1, later elements still count, but the result is CANON_NAN.
- Single-element packet: the result equals that element, count=1.
- Counter saturation: at 2^CNT_W-1 the counter holds. Reduction continues correctly.
- mode changes mid-packet are ignored. mode_q applies until the packet ends.
- Assertions: in_valid low or in_data changing before transfer is legal. The engine never accepts an element while in DONE.

Decomposition:
- Shared package fpu_pkg holds:
  - constants CANON_NAN, FMAX=1'b1, FMIN=1'b0
  - field widths EXP_W=8, FRAC_W=23
  - a state enum {IDLE, ACCUM, DONE}
- One combinational sub-module, fp_minmax_cmp (inputs a, b, mode; output y), implements the compare rules above. fpu_minmax_reduce instantiates it once, with A=acc and B=in_data.
- The FSM, counters and handshake logic live in fpu_minmax_reduce.

Test Plan:
- fmax packet {3F800000(1.0), C0000000(-2.0), 40400000(3.0) last}, out_ready=1 -> out_data=40400000, out_count=3, out_nan=0, out_valid one cycle after the last transfer.
- fmin packet {00000000(+0), 80000000(-0) last} -> 80000000. The same packet with fmax -> 00000000. fmin {C0400000, C0000000 last} -> C0400000.
- NaN sticky, fmax {3F800000, 7FC00001, 7F800000(+inf) last} -> out_data=FFC00000, out_nan=1, out_count=3.
- Backpressure: hold out_ready=0 for 5 cycles after the result. Check that out_data, out_nan and out_count are stable, in_ready=0, and extra input elements are not accepted. Release, then check that the next packet starts in IDLE.
- Mid-packet reset: send 2 elements without last, pulse rst for 1 cycle -> no out_valid. The next single-element packet 42280000 gives out_data=42280000, count=1.
- Tie and mode latching: fmin packet {40000000, 40000000 last} with mode toggled to 1 on the second element -> out_data=40000000 and the min rule applies. With CNT_W=2, send 5 elements -> out_count=3.
